// File: rtl/scan_seq24.sv
// Lane scan sequencer driving the 2-bit select of a 2-to-4 decoder.
// Optional SCAN_SEQ24_BLANK_EN inserts a one-cycle blank between consecutive lanes.
module scan_seq24 #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done
);

`ifdef SCAN_SEQ24_BLANK_EN
  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

  state_t             state;
  logic               mode_q;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  // {found, index} of the lowest set bit
  function automatic logic [2:0] lowest(input logic [3:0] m);
    lowest = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest = {1'b1, 2'(i)};
  endfunction

  // {found, index} of the lowest set bit strictly above cur
  function automatic logic [2:0] next_up(input logic [3:0] m, input logic [1:0] cur);
    next_up = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_up = {1'b1, 2'(i)};
  endfunction

  logic [2:0] lo_start, lo_q, nxt_hi;
  assign lo_start = lowest(mask);
  assign lo_q     = lowest(mask_q);
  assign nxt_hi   = next_up(mask_q, sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'b00;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
      mask_q    <= 4'b0000;
      dwell_q   <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (mask != 4'b0000)) begin
            mode_q    <= mode;
            mask_q    <= mask;
            dwell_q   <= dwell;
            sel       <= lo_start[1:0];
            cnt       <= dwell;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (stop) begin
            state     <= IDLE;
            sel       <= 2'b00;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (nxt_hi[2] || mode_q) begin
            // wrap to the lowest lane only when no higher lane remains
            sel <= nxt_hi[2] ? nxt_hi[1:0] : lo_q[1:0];
            cnt <= dwell_q;
`ifdef SCAN_SEQ24_BLANK_EN
            sel_valid <= 1'b0;
            state     <= BLANK;
`endif
          end else begin
            state     <= IDLE;
            sel       <= 2'b00;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
`ifdef SCAN_SEQ24_BLANK_EN
        BLANK: begin
          if (stop) begin
            state     <= IDLE;
            sel       <= 2'b00;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            sel_valid <= 1'b1;
            state     <= DWELL;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          sel       <= 2'b00;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_seq24.sv
// Directed testbench for scan_seq24; observed word is {sel, sel_valid, busy, done}.
module tb_scan_seq24;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [7:0] dwell = 8'd0;
  logic [1:0] sel;
  logic       sel_valid, busy, done;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] obs, expv;

  scan_seq24 #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL reset_state: got %b want %b", obs, expv); end
    rst_n = 1'b1;
    start = 1'b1; mask = 4'b0000;
    step();
    start = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL start_mask0: got %b want %b", obs, expv); end
  endtask

  task automatic test_oneshot();
    mask = 4'b1111; dwell = 8'd2; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs = {sel, sel_valid, busy, done}; expv = {2'(i / 3), 3'b110}; n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL oneshot_cyc%0d: got %b want %b", i, obs, expv); end
      step();
    end
    obs = {sel, sel_valid, busy, done}; expv = 5'b00001; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL oneshot_done: got %b want %b", obs, expv); end
    // restart accepted while done is high
    mask = 4'b0001; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00110; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL restart_lane: got %b want %b", obs, expv); end
    step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b00001; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL restart_done: got %b want %b", obs, expv); end
    step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL done_pulse_width: got %b want %b", obs, expv); end
  endtask

  task automatic test_continuous();
    mask = 4'b1010; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0; mask = 4'b0001; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {sel, sel_valid, busy, done}; expv = {((i % 2) != 0) ? 2'd3 : 2'd1, 3'b110}; n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL cont_cyc%0d: got %b want %b", i, obs, expv); end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL cont_stop: got %b want %b", obs, expv); end
  endtask

  task automatic test_stop();
    mask = 4'b1111; dwell = 8'd5; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b01110; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL stop_in_lane1: got %b want %b", obs, expv); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL stop_idle: got %b want %b", obs, expv); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL start_and_stop: got %b want %b", obs, expv); end
  endtask

  task automatic test_ignored_start();
    mask = 4'b0011; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {sel, sel_valid, busy, done}; expv = {2'(i / 4), 3'b110}; n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL busy_start_cyc%0d: got %b want %b", i, obs, expv); end
      start = (i == 1);
      if (i == 1) begin mask = 4'b1111; dwell = 8'd0; end
      step();
    end
    start = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00001; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL busy_start_done: got %b want %b", obs, expv); end
  endtask

  task automatic test_reset_mid();
    mask = 4'b1111; dwell = 8'd3; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b10110; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL pre_reset_lane2: got %b want %b", obs, expv); end
    #2 rst_n = 1'b0;
    #1;
    obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL async_reset: got %b want %b", obs, expv); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {sel, sel_valid, busy, done}; expv = 5'b00000; n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL post_reset_idle%0d: got %b want %b", i, obs, expv); end
    end
    mask = 4'b0100; dwell = 8'd0; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    obs = {sel, sel_valid, busy, done}; expv = 5'b10110; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL post_reset_start: got %b want %b", obs, expv); end
    step();
    obs = {sel, sel_valid, busy, done}; expv = 5'b00001; n_cmp++;
    if (obs !== expv) begin n_err++; $display("FAIL post_reset_done: got %b want %b", obs, expv); end
  endtask

`ifdef SCAN_SEQ24_BLANK_EN
  task automatic test_blank();
    logic [4:0] seq [6];
    seq = '{5'b00110, 5'b00110, 5'b10010, 5'b10110, 5'b10110, 5'b00001};
    mask = 4'b0101; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs = {sel, sel_valid, busy, done}; expv = seq[i]; n_cmp++;
      if (obs !== expv) begin n_err++; $display("FAIL blank_cyc%0d: got %b want %b", i, obs, expv); end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SCAN_SEQ24_BLANK_EN
    test_blank();
`else
    test_oneshot();
    test_continuous();
    test_stop();
    test_ignored_start();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
